// File: rtl/isochronous_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// isochronous_pkg : width helpers and modulo arithmetic for isochronous blocks
// Revision 1.0
// ----------------------------------------------------------------------------
package isochronous_pkg;

   function automatic int ptr_width(input int depth);
      return $clog2(2 * depth);
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // (a - b) mod m, for operands already reduced into [0, m)
   function automatic int unsigned mod_sub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned m);
      return (a >= b) ? (a - b) : (a + m - b);
   endfunction

endpackage
`default_nettype wire

// File: rtl/isochronous_strobe_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// isochronous_strobe_gen : one-in-RATIO enable strobe for a divided rate domain
// Revision 1.0
// ----------------------------------------------------------------------------
module isochronous_strobe_gen #(
   parameter int RATIO = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic en_o
);

   localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign en_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/isochronous_stream_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// isochronous_stream_bridge : valid/ready FIFO between two strobe-gated domains
// Revision 1.0
// ----------------------------------------------------------------------------
module isochronous_stream_bridge
   import isochronous_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          src_en_i,
   input  logic                          src_valid_i,
   output logic                          src_ready_o,
   input  logic [DATA_WIDTH-1:0]         src_data_i,
   output logic [cnt_width(DEPTH)-1:0]   src_free_o,
   input  logic                          dst_en_i,
   output logic                          dst_valid_o,
   input  logic                          dst_ready_i,
   output logic [DATA_WIDTH-1:0]         dst_data_o,
   output logic [cnt_width(DEPTH)-1:0]   dst_fill_o
);

   localparam int          PTR_W   = ptr_width(DEPTH);
   localparam int          CNT_W   = cnt_width(DEPTH);
   localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PTR_MOD = 2 * DEPTH;

   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [PTR_W-1:0]      src_rptr_q, src_rptr_d;
   logic [PTR_W-1:0]      dst_wptr_q, dst_wptr_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  push;
   logic                  pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == PTR_MOD - 1) ? '0 : p + 1'b1;
   endfunction

   // Pointers run over 2*DEPTH; the storage slot folds the upper half back down
   function automatic logic [IDX_W-1:0] slot(input logic [PTR_W-1:0] p);
      return (32'(p) >= DEPTH) ? IDX_W'(32'(p) - DEPTH) : IDX_W'(p);
   endfunction

   always_comb begin
      src_free_o  = CNT_W'(32'(DEPTH) - mod_sub(32'(wptr_q), 32'(src_rptr_q), PTR_MOD));
      src_ready_o = (src_free_o != '0);
      dst_fill_o  = CNT_W'(mod_sub(32'(dst_wptr_q), 32'(rptr_q), PTR_MOD));
      dst_valid_o = (dst_fill_o != '0);
      dst_data_o  = mem_q[slot(rptr_q)];
   end

   always_comb begin
      push       = src_en_i & src_valid_i & src_ready_o;
      pop        = dst_en_i & dst_valid_o & dst_ready_i;
      wptr_d     = push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d     = pop  ? ptr_inc(rptr_q) : rptr_q;
      // Snapshots see the pointer before this cycle's update, keeping views conservative
      src_rptr_d = src_en_i ? rptr_q : src_rptr_q;
      dst_wptr_d = dst_en_i ? wptr_q : dst_wptr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         src_rptr_q <= '0;
         dst_wptr_q <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         src_rptr_q <= src_rptr_d;
         dst_wptr_q <= dst_wptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[slot(wptr_q)] <= src_data_i;
      end
   end

`ifndef SYNTHESIS
   logic                  hold_pend_q;
   logic [DATA_WIDTH-1:0] hold_data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_pend_q <= 1'b0;
         hold_data_q <= '0;
      end else if (src_en_i) begin
         if (hold_pend_q) begin
            a_src_hold: assert (src_valid_i && (src_data_i == hold_data_q));
         end
         hold_pend_q <= src_valid_i & ~src_ready_o;
         hold_data_q <= src_data_i;
      end
   end

   a_src_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (!$past(src_en_i) && !$past(rst_i)) |-> $stable({src_ready_o, src_free_o}));

   a_dst_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (!$past(dst_en_i) && !$past(rst_i)) |-> $stable({dst_valid_o, dst_fill_o}));

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      push |-> (mod_sub(32'(wptr_q), 32'(rptr_q), PTR_MOD) < DEPTH));

   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      pop |-> (mod_sub(32'(wptr_q), 32'(rptr_q), PTR_MOD) != 0));
`endif

endmodule
`default_nettype wire
